vga_scan_driver: RTL

VGA_SCAN_DRIVER -- requirements
Module: vga_scan_driver

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_axis_counter.sv | 84 ++++++++
 rtl/vga_scan_driver.sv | 124 ++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the per-axis scan phase encoding
// shared by the VGA scan driver and its axis counters.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV  = 4;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Wide enough for any axis total up to 4095 positions.
  localparam int CNT_W        = 12;

  typedef enum logic [1:0] {
    ACT  = 2'd0,
    FP   = 2'd1,
    SYNC = 2'd2,
    BP   = 2'd3
  } phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: a position counter plus a phase FSM (ACT/FP/SYNC/BP) that
// always describes the phase of the current count value.
module vga_axis_counter
  import vga_timing_pkg::phase_e, vga_timing_pkg::CNT_W;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output phase_e           state,
  output logic             wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] FP_LAST   = CNT_W'(ACTIVE + FP - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] count_r;
  phase_e           state_r;
  phase_e           state_nx_s;
  logic             wrap_s;

  assign wrap_s = en && (count_r == LAST);

  // Position counter, wrapping after the last back-porch position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (wrap_s) begin
      count_r <= {CNT_W{1'b0}};
    end else if (en) begin
      count_r <= count_r + CNT_W'(1);
    end
  end

  // Phase state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= vga_timing_pkg::ACT;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Phase changes on the same step that moves count into the next phase.
  always_comb begin
    state_nx_s = state_r;
    if (en) begin
      case (state_r)
        vga_timing_pkg::ACT: begin
          if (count_r == ACT_LAST) state_nx_s = vga_timing_pkg::FP;
          else                     state_nx_s = state_r;
        end
        vga_timing_pkg::FP: begin
          if (count_r == FP_LAST) state_nx_s = vga_timing_pkg::SYNC;
          else                    state_nx_s = state_r;
        end
        vga_timing_pkg::SYNC: begin
          if (count_r == SYNC_LAST) state_nx_s = vga_timing_pkg::BP;
          else                      state_nx_s = state_r;
        end
        vga_timing_pkg::BP: begin
          if (wrap_s) state_nx_s = vga_timing_pkg::ACT;
          else        state_nx_s = state_r;
        end
        default: state_nx_s = vga_timing_pkg::ACT;
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  assign count = count_r;
  assign state = state_r;
  assign wrap  = wrap_s;

endmodule

// File: rtl/vga_scan_driver.sv
// VGA raster generator: pixel-rate divider, horizontal/vertical scan axes and
// a registered video/sync stage that trails the scan position by one pixel.
module vga_scan_driver
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        color,
  output logic signed [31:0] pix_x,
  output logic signed [31:0] pix_y,
  output logic               active,
  output logic               hsync,
  output logic               vsync,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               frame_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_r;
  logic             pix_en_s;
  logic [CNT_W-1:0] h_cnt_s;
  logic [CNT_W-1:0] v_cnt_s;
  phase_e           h_state_s;
  phase_e           v_state_s;
  logic             h_wrap_s;
  logic             v_wrap_s;
  logic             active_s;
  logic [11:0]      rgb_r;
  logic             hsync_r;
  logic             vsync_r;
  logic             frame_r;

  // With CLK_DIV=1 the divider sits at 0 = DIV_LAST, so every clk is a pixel.
  assign pix_en_s = (div_r == DIV_LAST);

  // Pixel-rate divider.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_r <= {DIV_W{1'b0}};
    end else if (pix_en_s) begin
      div_r <= {DIV_W{1'b0}};
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en_s),
    .count (h_cnt_s),
    .state (h_state_s),
    .wrap  (h_wrap_s)
  );

  // h_wrap already includes pix_en, so it is the vertical step strobe.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk   (clk),
    .reset (reset),
    .en    (h_wrap_s),
    .count (v_cnt_s),
    .state (v_state_s),
    .wrap  (v_wrap_s)
  );

  assign active_s = (h_state_s == ACT) && (v_state_s == ACT);

  // Video and syncs describe the pixel whose period is ending at this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_r   <= 12'h000;
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
    end else if (pix_en_s) begin
      rgb_r   <= active_s ? color : 12'h000;
      hsync_r <= (h_state_s != SYNC);
      vsync_r <= (v_state_s != SYNC);
    end
  end

  // Frame pulse lands on the clk where the counters read (0,0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_r <= 1'b0;
    end else begin
      frame_r <= v_wrap_s;
    end
  end

  assign pix_x       = {{(32-CNT_W){1'b0}}, h_cnt_s};
  assign pix_y       = {{(32-CNT_W){1'b0}}, v_cnt_s};
  assign active      = active_s;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign vga_r       = rgb_r[11:8];
  assign vga_g       = rgb_r[7:4];
  assign vga_b       = rgb_r[3:0];
  assign frame_start = frame_r;

endmodule
